dmux8_scatter_ctrl: RTL and testbench
=====================================

// Module: dmux8_scatter_ctrl
// PURPOSE
//   Sequencer for the dmux8way16 routing datapath. Accepts 16-bit words over a valid/ready
//   stream and steers each one to one of 8 destination lanes, selected by address or round-robin.
//   Holds each word until the destination takes it; drops it after a programmable stall timeout.
//   Sits between a single word producer (CPU/DMA write port) and 8 register banks or peripherals.
// PARAMETERS
//   TIMEOUT   64   stall cycles before a held word is dropped; 0 = never drop
//   CNT_W     16   width of sent_count (wraps)
// PORTS
//   clk          in   1    clock; all state on rising edge
//   rst_n        in   1    reset; asynchronous, active-low
//   in_data      in   16   word to route
//   in_dest      in   3    destination lane (addressed mode)
//   in_mode      in   1    0 = addressed (use in_dest), 1 = round-robin
//   in_valid     in   1    producer has a word
//   in_ready     out  1    controller accepts a word this cycle
//   out_data     out  128  lane k = out_data[16k+15:16k]; from dmux8way16; non-selected lanes 0
//   out_valid    out  8    one-hot valid for the held word's lane; 0 when idle
//   out_ready    in   8    per-lane consumer ready
//   sel          out  3    lane of held word (dmux select)
//   drop_pulse   out  1    1-cycle pulse when a word is dropped on timeout
//   drop_count   out  8    saturating count of dropped words (stops at 255)
//   sent_count   out  CNT_W  count of delivered words, wraps
// BEHAVIOUR
//   - Reset (rst_n low, async): state IDLE, hold reg 0, sel 0, rr_ptr 0, wait_cnt 0, all counters 0,
//     out_valid 0, out_data 0, drop_pulse 0, in_ready forced 0 while rst_n low.
//   - States: IDLE (nothing held), SEND (word held, out_valid[sel] = 1).
//   - Accept = in_valid & in_ready. in_ready = IDLE | (SEND & out_ready[sel]) | (SEND & timeout_hit).
//   - On accept: hold <= in_data; sel <= in_mode ? rr_ptr : in_dest; state -> SEND; wait_cnt <= 0.
//     In RR mode rr_ptr <= rr_ptr+1 (7 wraps to 0); rr_ptr unchanged in addressed mode.
//   - Latency: word accepted at edge N is presented on the lane in cycle N+1 (1 cycle).
//   - Deliver = SEND & out_ready[sel]: sent_count +1. If accept occurs in the same cycle, stay in SEND
//     with the new word (back-to-back, 1 word/cycle sustained); otherwise -> IDLE.
//   - Stall: SEND & ~out_ready[sel] -> wait_cnt +1. timeout_hit = TIMEOUT!=0 & wait_cnt==TIMEOUT-1
//     & ~out_ready[sel]. On timeout_hit: word dropped, drop_pulse = 1 next cycle, drop_count +1
//     (saturating), state -> IDLE or SEND with new word if accept in the same cycle.
//   - out_ready on non-selected lanes is ignored; out_valid is never multi-hot.
//   - in_mode and in_dest are sampled only on accept; changes while holding have no effect.
//   - out_data: dmux of hold by sel while in SEND; all 128 bits 0 in IDLE.
//   - Reset mid-transfer: held word discarded, no count updates, outputs to reset values at once.
// STRUCTURE
//   - Shared header hack_defs.vh: LANES=8, SEL_W=3, WORD_W=16, state encodings ST_IDLE/ST_SEND.
//   - One sub-module: existing dmux8way16 (in=hold gated by SEND, sel=sel, a..h -> out_data lanes 0..7).
//   - Local: 1-bit FSM, 16-bit hold reg, 3-bit rr_ptr, wait counter sized clog2(TIMEOUT+1), counters.
// TESTING
//   1. Reset, in_mode=0, in_dest=5, in_data=16'h1234, out_ready=8'hFF, valid 1 cycle ->
//      next cycle out_valid=8'b0010_0000, lane5=16'h1234, other lanes 0, sent_count=1.
//   2. in_mode=1, 9 back-to-back words 1..9, out_ready=8'hFF -> lanes 0..7 then 0, one word per cycle,
//      in_ready held 1, sent_count=9.
//   3. Addressed dest=2, out_ready[2]=0 for 10 cycles then 1 -> word held steady, in_ready=0 for
//      the stall, delivered on cycle of ready, drop_count=0.
//   4. TIMEOUT=4, dest=3, out_ready=0 -> drop after 4 stall cycles, drop_pulse exactly 1 cycle,
//      drop_count=1, out_valid=0; 300 drops -> drop_count=255.
//   5. rst_n low mid-SEND (async, between edges) -> out_valid/out_data 0 immediately, counters 0,
//      rr_ptr 0; first RR word after release goes to lane 0.
//   6. Stall with out_ready=8'b1111_0111 on dest=3 -> no delivery; other lanes' ready ignored.

Source files
------------

// File: rtl/dmux8_scatter_ctrl_pkg.sv
// Shared widths and FSM encoding for the dmux8 scatter controller.
// Imported by the controller top and the dmux8way16 lane router.
package dmux8_scatter_ctrl_pkg;

   localparam int LANES    = 8;
   localparam int SEL_W    = 3;
   localparam int WORD_W   = 16;
   localparam int DROP_W   = 8;
   localparam int OUT_W    = LANES * WORD_W;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

endpackage

// File: rtl/dmux8_scatter_ctrl_dmux8way16.sv
// 16-bit 1-to-8 demultiplexer: routes in to the output picked by sel.
// Non-selected outputs are driven to zero.
module dmux8way16
   import dmux8_scatter_ctrl_pkg::*;
(
   input  logic [WORD_W-1:0] in,
   input  logic [SEL_W-1:0]  sel,
   output logic [WORD_W-1:0] a,
   output logic [WORD_W-1:0] b,
   output logic [WORD_W-1:0] c,
   output logic [WORD_W-1:0] d,
   output logic [WORD_W-1:0] e,
   output logic [WORD_W-1:0] f,
   output logic [WORD_W-1:0] g,
   output logic [WORD_W-1:0] h
);

   assign a = (sel == 3'd0) ? in : '0;
   assign b = (sel == 3'd1) ? in : '0;
   assign c = (sel == 3'd2) ? in : '0;
   assign d = (sel == 3'd3) ? in : '0;
   assign e = (sel == 3'd4) ? in : '0;
   assign f = (sel == 3'd5) ? in : '0;
   assign g = (sel == 3'd6) ? in : '0;
   assign h = (sel == 3'd7) ? in : '0;

endmodule

// File: rtl/dmux8_scatter_ctrl.sv
// Scatter sequencer: holds one 16-bit word and presents it to one of 8 lanes
// (addressed or round-robin) until taken, dropping it after a stall timeout.
module dmux8_scatter_ctrl
   import dmux8_scatter_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [WORD_W-1:0]   in_data,
   input  logic [SEL_W-1:0]    in_dest,
   input  logic                in_mode,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [OUT_W-1:0]    out_data,
   output logic [LANES-1:0]    out_valid,
   input  logic [LANES-1:0]    out_ready,
   output logic [SEL_W-1:0]    sel,
   output logic                drop_pulse,
   output logic [DROP_W-1:0]   drop_count,
   output logic [CNT_W-1:0]    sent_count
);

   // TIMEOUT=0 disables dropping; keep the counter at least one bit wide.
   localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit TIMEOUT_EN = (TIMEOUT != 0);

   state_t              r_state;
   state_t              w_state_next;
   logic [WORD_W-1:0]   r_hold;
   logic [SEL_W-1:0]    r_sel;
   logic [SEL_W-1:0]    r_rr_ptr;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic                r_drop_pulse;
   logic [DROP_W-1:0]   r_drop_count;
   logic [CNT_W-1:0]    r_sent_count;

   logic                w_send;
   logic                w_lane_ready;
   logic                w_deliver;
   logic                w_timeout_hit;
   logic                w_accept;
   logic [WORD_W-1:0]   w_dmux_in;

   assign w_send        = (r_state == ST_SEND);
   assign w_lane_ready  = out_ready[r_sel];
   assign w_deliver     = w_send & w_lane_ready;
   assign w_timeout_hit = TIMEOUT_EN & w_send & ~w_lane_ready & (r_wait_cnt == WAIT_LAST);
   // rst_n gates in_ready so the producer never sees a handshake during reset.
   assign in_ready      = rst_n & (~w_send | w_deliver | w_timeout_hit);
   assign w_accept      = in_valid & in_ready;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // NOTE: the default assignment first guarantees no latch on w_state_next.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_next = ST_SEND;
         ST_SEND: begin
            if (w_accept)                      w_state_next = ST_SEND;
            else if (w_deliver | w_timeout_hit) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold       <= '0;
         r_sel        <= '0;
         r_rr_ptr     <= '0;
         r_wait_cnt   <= '0;
         r_drop_pulse <= 1'b0;
         r_drop_count <= '0;
         r_sent_count <= '0;
      end else begin
         r_drop_pulse <= w_timeout_hit;
         if (w_accept) begin
            r_hold     <= in_data;
            r_sel      <= in_mode ? r_rr_ptr : in_dest;
            r_wait_cnt <= '0;
            if (in_mode) r_rr_ptr <= r_rr_ptr + SEL_W'(1);
         end else if (w_send & ~w_lane_ready) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
         end
         if (w_deliver) r_sent_count <= r_sent_count + CNT_W'(1);
         if (w_timeout_hit && (r_drop_count != '1)) r_drop_count <= r_drop_count + DROP_W'(1);
      end
   end

   assign w_dmux_in = w_send ? r_hold : '0;

   dmux8way16 u_dmux (
      .in  (w_dmux_in),
      .sel (r_sel),
      .a   (out_data[0*WORD_W +: WORD_W]),
      .b   (out_data[1*WORD_W +: WORD_W]),
      .c   (out_data[2*WORD_W +: WORD_W]),
      .d   (out_data[3*WORD_W +: WORD_W]),
      .e   (out_data[4*WORD_W +: WORD_W]),
      .f   (out_data[5*WORD_W +: WORD_W]),
      .g   (out_data[6*WORD_W +: WORD_W]),
      .h   (out_data[7*WORD_W +: WORD_W])
   );

   assign out_valid  = w_send ? (LANES'(1) << r_sel) : '0;
   assign sel        = r_sel;
   assign drop_pulse = r_drop_pulse;
   assign drop_count = r_drop_count;
   assign sent_count = r_sent_count;

endmodule

// File: tb/tb_dmux8_scatter_ctrl.sv
// Directed bench: a default-timeout controller plus a TIMEOUT=4 copy sharing
// the same stimulus; the short-timeout copy is only examined for drop behaviour.
module tb_dmux8_scatter_ctrl;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [15:0]   in_data;
   logic [2:0]    in_dest;
   logic          in_mode;
   logic          in_valid;
   logic [7:0]    out_ready;

   logic          in_ready,   t4_in_ready;
   logic [127:0]  out_data,   t4_out_data;
   logic [7:0]    out_valid,  t4_out_valid;
   logic [2:0]    sel,        t4_sel;
   logic          drop_pulse, t4_drop_pulse;
   logic [7:0]    drop_count, t4_drop_count;
   logic [15:0]   sent_count, t4_sent_count;

   int n_checks = 0;
   int n_bad    = 0;

   always #5 clk = ~clk;

   dmux8_scatter_ctrl dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_dest(in_dest), .in_mode(in_mode),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .sel(sel), .drop_pulse(drop_pulse), .drop_count(drop_count),
      .sent_count(sent_count)
   );

   dmux8_scatter_ctrl #(.TIMEOUT(4)) dut_t4 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_dest(in_dest), .in_mode(in_mode),
      .in_valid(in_valid), .in_ready(t4_in_ready), .out_data(t4_out_data), .out_valid(t4_out_valid),
      .out_ready(out_ready), .sel(t4_sel), .drop_pulse(t4_drop_pulse), .drop_count(t4_drop_count),
      .sent_count(t4_sent_count)
   );

   typedef struct {
      logic        mode;
      logic [2:0]  dest;
      logic [15:0] data;
      logic        exp_in_ready;
      int          exp_lane;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      in_mode   = 1'b0;
      in_dest   = '0;
      in_data   = '0;
      out_ready = 8'hFF;
      rst_n     = 1'b0;
      #12;
      rst_n = 1'b1;
      tick();
   endtask

   function automatic logic [127:0] lane_word(input logic [15:0] d, input int lane);
      return 128'(d) << (16 * lane);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // RR words 1..9 walk lanes 0..7,0; addressed words leave rr_ptr alone.
      for (int i = 0; i < 9; i++)
         vecs[i] = '{mode: 1'b1, dest: 3'd0, data: 16'(i + 1), exp_in_ready: 1'b1, exp_lane: i % 8};
      vecs[9]  = '{mode: 1'b0, dest: 3'd6, data: 16'h00A0, exp_in_ready: 1'b1, exp_lane: 6};
      vecs[10] = '{mode: 1'b0, dest: 3'd1, data: 16'h00B0, exp_in_ready: 1'b1, exp_lane: 1};
      vecs[11] = '{mode: 1'b1, dest: 3'd7, data: 16'h000C, exp_in_ready: 1'b1, exp_lane: 1};

      // Reset state
      in_valid = 1'b0; in_mode = 1'b0; in_dest = '0; in_data = '0; out_ready = 8'hFF;
      rst_n = 1'b0;
      #3;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_counts", {drop_pulse, drop_count, sent_count}, 0);
      #9;
      rst_n = 1'b1;
      tick();

      // 1: single addressed word to lane 5
      in_mode = 1'b0; in_dest = 3'd5; in_data = 16'h1234; in_valid = 1'b1;
      check("t1_in_ready_idle", in_ready, 1);
      tick();
      in_valid = 1'b0;
      check("t1_out_valid", out_valid, 8'b0010_0000);
      check("t1_out_data", out_data, lane_word(16'h1234, 5));
      check("t1_sel", sel, 3'd5);
      tick();
      check("t1_idle_after", out_valid, 0);
      check("t1_sent", sent_count, 1);

      // 2: back-to-back table
      for (int i = 0; i < 12; i++) begin
         in_mode = vecs[i].mode; in_dest = vecs[i].dest; in_data = vecs[i].data; in_valid = 1'b1;
         check($sformatf("t2_in_ready[%0d]", i), in_ready, vecs[i].exp_in_ready);
         tick();
         check($sformatf("t2_out_valid[%0d]", i), out_valid, 8'(1) << vecs[i].exp_lane);
         check($sformatf("t2_out_data[%0d]", i), out_data, lane_word(vecs[i].data, vecs[i].exp_lane));
      end
      in_valid = 1'b0;
      tick();
      check("t2_sent", sent_count, 13);
      check("t2_idle", out_valid, 0);

      // 3: stall on lane 2 for 10 cycles; mode/dest changes while holding ignored
      in_mode = 1'b0; in_dest = 3'd2; in_data = 16'hC0DE; in_valid = 1'b1; out_ready = 8'hFB;
      tick();
      in_valid = 1'b0; in_mode = 1'b1; in_dest = 3'd7; in_data = 16'hFFFF;
      for (int i = 0; i < 10; i++) begin
         check("t3_hold_valid", out_valid, 8'b0000_0100);
         check("t3_hold_data", out_data, lane_word(16'hC0DE, 2));
         check("t3_in_ready_low", in_ready, 0);
         if (i < 9) tick();
      end
      out_ready = 8'hFF;
      #1;
      check("t3_in_ready_on_deliver", in_ready, 1);
      tick();
      check("t3_delivered", out_valid, 0);
      check("t3_sent", sent_count, 14);
      check("t3_no_drop", {drop_pulse, drop_count}, 0);

      // 4: timeout drops on the TIMEOUT=4 instance
      do_reset();
      in_mode = 1'b0; in_dest = 3'd3; in_data = 16'h3333; in_valid = 1'b1; out_ready = 8'h00;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t4_stall_valid[%0d]", i), t4_out_valid, 8'b0000_1000);
         check($sformatf("t4_stall_pulse[%0d]", i), t4_drop_pulse, 0);
         check($sformatf("t4_stall_in_ready[%0d]", i), t4_in_ready, (i == 3));
         tick();
      end
      check("t4_drop_pulse", t4_drop_pulse, 1);
      check("t4_drop_count1", t4_drop_count, 1);
      check("t4_dropped_valid", t4_out_valid, 0);
      check("t4_dropped_data", t4_out_data, 0);
      tick();
      check("t4_pulse_one_cycle", t4_drop_pulse, 0);
      check("t4_no_send", t4_sent_count, 0);
      in_valid = 1'b1;
      for (int i = 0; i < 1300; i++) tick();
      in_valid = 1'b0;
      check("t4_drop_saturated", t4_drop_count, 255);

      // 5: async reset mid-SEND
      do_reset();
      in_mode = 1'b1; in_valid = 1'b1; in_data = 16'h5151; out_ready = 8'hFF;
      tick(); tick(); tick();
      in_valid = 1'b0; out_ready = 8'h00;
      tick();
      check("t5_pre_sent", sent_count, 2);
      check("t5_pre_valid", out_valid, 8'b0000_0100);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_async_valid", out_valid, 0);
      check("t5_async_data", out_data, 0);
      check("t5_async_sent", sent_count, 0);
      check("t5_async_in_ready", in_ready, 0);
      #10;
      rst_n = 1'b1;
      out_ready = 8'hFF; in_mode = 1'b1; in_data = 16'h0055; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t5_rr_restart", out_valid, 8'b0000_0001);
      check("t5_rr_data", out_data, lane_word(16'h0055, 0));

      // 6: other lanes' ready ignored
      do_reset();
      in_mode = 1'b0; in_dest = 3'd3; in_data = 16'h6666; in_valid = 1'b1; out_ready = 8'b1111_0111;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("t6_hold_valid", out_valid, 8'b0000_1000);
         check("t6_in_ready", in_ready, 0);
         tick();
      end
      check("t6_sent", sent_count, 0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
